// File: rtl/vec_mem_ctrl.sv
// vec_mem_ctrl: whole-vector load/store command controller in front of a 512x32 vector memory
module vec_mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int VLEN   = 16,
    parameter int WORD_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [VLEN*WORD_W-1:0]   cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic                     rsp_err,
    output logic [VLEN*WORD_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic [VLEN*WORD_W-1:0]   mem_data_in,
    input  logic [VLEN*WORD_W-1:0]   mem_data_out,
    output logic                     busy
);
    // Highest legal base address, compared one bit wider so large addresses cannot wrap
    localparam logic [ADDR_W:0] MAX_BASE = (ADDR_W+1)'(DEPTH - VLEN);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    logic        r_write;
    logic [2:0]  r_cnt;
    logic        w_legal;

    assign w_legal = {1'b0, cmd_addr} <= MAX_BASE;

    // Command FSM; every output is a register so reset clears them without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_write          <= 1'b0;
            r_cnt            <= '0;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_rdata        <= '0;
            mem_address      <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_data_in      <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    r_write   <= cmd_write;
                    if (w_legal) begin
                        r_state          <= ISSUE;
                        mem_address      <= cmd_addr;
                        mem_read_enable  <= !cmd_write;
                        mem_write_enable <= cmd_write;
                        if (cmd_write) mem_data_in <= cmd_wdata;
                    end else begin
                        r_state   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= cmd_write;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ISSUE: begin
                    mem_read_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                    if (r_write) begin
                        r_state   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= 3'(RD_LAT);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= mem_data_out;
                    end
                end
                RESP: if (rsp_ready) begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
